// File: rtl/nbout_psum_ctrl.sv
// NBout-side partial-sum sequencer for the NFU-2 stage: per output group it reads
// the stored partial sums, loads them into NFU-2, accumulates P passes and writes back.
module nbout_psum_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int G          = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int PASS_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_first,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [ADDR_WIDTH:0]     i_num_groups,
    input  logic [PASS_WIDTH-1:0]   i_num_passes,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_nb_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_nb_rd_addr,
    input  logic [G*BIT_WIDTH-1:0]  i_nb_rd_data,
    output logic [G*BIT_WIDTH-1:0]  o_partial_sum,
    output logic                    o_load_partial_sum,
    output logic                    o_acc_en,
    input  logic [G*BIT_WIDTH-1:0]  i_nfu_output,
    output logic                    o_nb_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_nb_wr_addr,
    output logic [G*BIT_WIDTH-1:0]  o_nb_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LOAD = 3'd2,
        S_ACC  = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_first;
    logic [ADDR_WIDTH-1:0]   r_base_addr;
    logic [ADDR_WIDTH:0]     r_num_groups;
    logic [PASS_WIDTH-1:0]   r_num_passes;
    logic [ADDR_WIDTH:0]     r_group_idx;
    logic [PASS_WIDTH-1:0]   r_pass_cnt;

    logic [ADDR_WIDTH:0]     w_group_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_last_pass;

    assign w_group_nxt = r_group_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Group address wraps silently at the top of NBout.
    assign w_addr      = r_base_addr + r_group_idx[ADDR_WIDTH-1:0];
    assign w_last_pass = (r_pass_cnt == (r_num_passes - PASS_WIDTH'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job parameter latches and group/pass counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first      <= 1'b0;
            r_base_addr  <= '0;
            r_num_groups <= '0;
            r_num_passes <= '0;
            r_group_idx  <= '0;
            r_pass_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_first      <= i_first;
                        r_base_addr  <= i_base_addr;
                        r_num_groups <= i_num_groups;
                        r_num_passes <= i_num_passes;
                        r_group_idx  <= '0;
                    end
                end
                S_LOAD:  r_pass_cnt  <= '0;
                S_ACC:   r_pass_cnt  <= r_pass_cnt + PASS_WIDTH'(1);
                S_WB:    r_group_idx <= w_group_nxt;
                default: r_pass_cnt  <= r_pass_cnt;
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_groups == '0) ? S_DONE : S_RD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD:   w_next = S_LOAD;
            S_LOAD: w_next = (r_num_passes == '0) ? S_WB : S_ACC;
            S_ACC:  w_next = w_last_pass ? S_WB : S_ACC;
            S_WB:   w_next = (w_group_nxt < r_num_groups) ? S_RD : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        o_busy             = (r_state != S_IDLE);
        o_done             = 1'b0;
        o_nb_rd_en         = 1'b0;
        o_nb_rd_addr       = '0;
        o_partial_sum      = '0;
        o_load_partial_sum = 1'b0;
        o_acc_en           = 1'b0;
        o_nb_wr_en         = 1'b0;
        o_nb_wr_addr       = '0;
        o_nb_wr_data       = '0;
        case (r_state)
            S_RD: begin
                o_nb_rd_en   = ~r_first;
                o_nb_rd_addr = w_addr;
            end
            S_LOAD: begin
                o_load_partial_sum = 1'b1;
                o_partial_sum      = r_first ? '0 : i_nb_rd_data;
            end
            S_ACC:  o_acc_en = 1'b1;
            S_WB: begin
                o_nb_wr_en   = 1'b1;
                o_nb_wr_addr = w_addr;
                o_nb_wr_data = i_nfu_output;
            end
            S_DONE: o_done = 1'b1;
            default: o_busy = (r_state != S_IDLE);
        endcase
    end

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Randomized bench for nbout_psum_ctrl: NBout memory and NFU-2 accumulator models,
// with a per-cycle expected trace built from job parameters.
module tb_nbout_psum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_first;
    logic [5:0]  i_base_addr;
    logic [6:0]  i_num_groups;
    logic [7:0]  i_num_passes;
    logic        o_busy;
    logic        o_done;
    logic        o_nb_rd_en;
    logic [5:0]  o_nb_rd_addr;
    logic [63:0] nb_rd_data;
    logic [63:0] o_partial_sum;
    logic        o_load_partial_sum;
    logic        o_acc_en;
    logic [63:0] nfu_out;
    logic        o_nb_wr_en;
    logic [5:0]  o_nb_wr_addr;
    logic [63:0] o_nb_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    nbout_psum_ctrl dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_first(i_first),
        .i_base_addr(i_base_addr), .i_num_groups(i_num_groups), .i_num_passes(i_num_passes),
        .o_busy(o_busy), .o_done(o_done), .o_nb_rd_en(o_nb_rd_en), .o_nb_rd_addr(o_nb_rd_addr),
        .i_nb_rd_data(nb_rd_data), .o_partial_sum(o_partial_sum),
        .o_load_partial_sum(o_load_partial_sum), .o_acc_en(o_acc_en), .i_nfu_output(nfu_out),
        .o_nb_wr_en(o_nb_wr_en), .o_nb_wr_addr(o_nb_wr_addr), .o_nb_wr_data(o_nb_wr_data)
    );

    always #5 clk = ~clk;

    // NBout memory with a one-cycle read latency and a preload port
    logic [63:0] mem [64];
    logic        pre_en;
    logic [5:0]  pre_addr;
    logic [63:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (o_nb_wr_en) mem[o_nb_wr_addr] <= o_nb_wr_data;
        if (o_nb_rd_en) nb_rd_data <= mem[o_nb_rd_addr];
    end

    function automatic logic [63:0] add_lanes(input logic [63:0] v, input logic [15:0] k);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = v[l*16 +: 16] + k;
        return r;
    endfunction

    // NFU-2 pipe register fed by an NFU-1 stand-in adding add_val per lane each accumulate
    logic [15:0] add_val;
    always @(posedge clk) begin
        if (o_load_partial_sum) nfu_out <= o_partial_sum;
        else if (o_acc_en) nfu_out <= add_lanes(nfu_out, add_val);
    end

    logic [63:0] exp_mem [64];

    typedef struct {
        bit          busy;
        bit          done;
        bit          rd;
        bit          ld;
        bit          acc;
        bit          wr;
        logic [5:0]  addr;
        logic [63:0] data;
    } cyc_t;

    function automatic cyc_t mk(input bit busy, input bit done, input bit rd, input bit ld,
                                input bit acc, input bit wr, input logic [5:0] addr,
                                input logic [63:0] data);
        cyc_t c;
        c.busy = busy; c.done = done; c.rd = rd; c.ld = ld;
        c.acc = acc; c.wr = wr; c.addr = addr; c.data = data;
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cycle(input cyc_t e);
        check_eq("busy",    64'(o_busy),             64'(e.busy));
        check_eq("done",    64'(o_done),             64'(e.done));
        check_eq("rd_en",   64'(o_nb_rd_en),         64'(e.rd));
        check_eq("load",    64'(o_load_partial_sum), 64'(e.ld));
        check_eq("acc_en",  64'(o_acc_en),           64'(e.acc));
        check_eq("wr_en",   64'(o_nb_wr_en),         64'(e.wr));
        check_eq("psum",    o_partial_sum,           e.ld ? e.data : 64'h0);
        if (e.rd) check_eq("rd_addr", 64'(o_nb_rd_addr), 64'(e.addr));
        if (e.wr) begin
            check_eq("wr_addr", 64'(o_nb_wr_addr), 64'(e.addr));
            check_eq("wr_data", o_nb_wr_data, e.data);
            exp_mem[e.addr] = e.data;
        end
    endtask

    task automatic run_job(input bit first, input int base, input int n, input int p,
                           input logic [15:0] add, input int poke_at, input int abort_at);
        cyc_t        tr[$];
        logic [63:0] shadow [64];
        logic [63:0] ld;
        logic [63:0] wr;
        logic [5:0]  a;
        int          busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < 64; i++) shadow[i] = exp_mem[i];
        for (int g = 0; g < n; g++) begin
            a  = 6'((base + g) % 64);
            ld = first ? 64'h0 : shadow[a];
            for (int l = 0; l < 4; l++)
                wr[l*16 +: 16] = 16'(int'(ld[l*16 +: 16]) + p * int'(add));
            shadow[a] = wr;
            tr.push_back(mk(1'b1, 1'b0, !first, 1'b0, 1'b0, 1'b0, a, 64'h0));
            tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, ld));
            for (int k = 0; k < p; k++) tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, 64'h0));
            tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, wr));
        end
        tr.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));

        add_val      = add;
        i_start      = 1'b1;
        i_first      = first;
        i_base_addr  = 6'(base);
        i_num_groups = 7'(n);
        i_num_passes = 8'(p);
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_first      = 1'($urandom);
        i_base_addr  = 6'($urandom);
        i_num_groups = 7'($urandom);
        i_num_passes = 8'($urandom);

        for (int c = 0; c < tr.size(); c++) begin
            if (c == poke_at + 1) i_start = 1'b0;
            check_cycle(tr[c]);
            busy_cnt += int'(o_busy);
            if (c == poke_at) begin
                i_start      = 1'b1;
                i_first      = 1'b1;
                i_num_groups = 7'($urandom_range(1, 127));
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));
                rst     = 1'b0;
                i_start = 1'b0;
                @(posedge clk); #1;
                check_cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));
                return;
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        check_cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(n * (p + 3) + 1));
    endtask

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_first      = 1'b0;
        i_base_addr  = 6'd0;
        i_num_groups = 7'd0;
        i_num_passes = 8'd0;
        add_val      = 16'd0;
        pre_en       = 1'b0;
        pre_addr     = 6'd0;
        pre_data     = 64'h0;
        @(posedge clk); #1;
        pre_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pre_addr = 6'(i);
            pre_data = (i == 5) ? 64'h0004_0003_0002_0001 : {$urandom, $urandom};
            exp_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        check_cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));
        rst = 1'b0;
        @(posedge clk); #1;
        check_cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 64'h0));

        run_job(1'b0, 5, 1, 3, 16'd10, -1, -1);
        check_eq("single_group_wb", mem[5], 64'h0022_0021_0020_001F);
        run_job(1'b1, 0, 2, 2, 16'($urandom), -1, -1);
        run_job(1'b0, 62, 3, 1, 16'($urandom), -1, -1);
        run_job(1'b0, 30, 0, 4, 16'($urandom), -1, -1);
        run_job(1'b0, 10, 2, 0, 16'($urandom | 1), -1, -1);
        run_job(1'b0, 20, 4, 3, 16'($urandom), 3, 15);
        run_job(1'b0, 20, 4, 2, 16'($urandom), -1, -1);
        for (int j = 0; j < 8; j++) begin
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 8),
                    $urandom_range(0, 5), 16'($urandom), -1, -1);
        end

        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) check_eq("nbout_contents", mem[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
